// File: rtl/sonic_arb_pkg.sv
// Shared types and constants for the sonic PCIe TX/MSI arbiter.
package sonic_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/sonic_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward from last+1.
module sonic_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Offsets 1..NUM_REQ visit every requester once, ending at last itself.
  always_comb begin
    int pos;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(last) + k) % NUM_REQ;
      if (!valid && req[IDX_W'(pos)]) begin
        valid                = 1'b1;
        idx                  = IDX_W'(pos);
        grant[IDX_W'(pos)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sonic_pcie_tx_arbiter.sv
// Round-robin arbiter sharing the PCIe Avalon-ST TX port between NUM_REQ requesters.
// Define SONIC_TX_ARB_MSI_EN to also arbitrate the MSI request port.
module sonic_pcie_tx_arbiter
  import sonic_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int GRANT_TIMEOUT = 1024
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_tx_ready,
  input  logic [NUM_REQ-1:0]       req_tx_busy,
  output logic [NUM_REQ-1:0]       req_tx_sel,
  output logic [NUM_REQ-1:0]       req_tx_ready_others,
  input  logic [NUM_REQ-1:0]       req_tx_req,
  input  logic [NUM_REQ-1:0]       req_tx_dv,
  input  logic [NUM_REQ-1:0]       req_tx_dfr,
  input  logic [NUM_REQ-1:0]       req_tx_err,
  input  logic [NUM_REQ*128-1:0]   req_tx_desc,
  input  logic [NUM_REQ*128-1:0]   req_tx_data,
  output logic [NUM_REQ-1:0]       req_tx_ack,
  output logic [NUM_REQ-1:0]       req_tx_ws,
  output logic                     tx_req,
  output logic                     tx_dv,
  output logic                     tx_dfr,
  output logic                     tx_err,
  output logic [127:0]             tx_desc,
  output logic [127:0]             tx_data,
  input  logic                     tx_ack,
  input  logic                     tx_ws,
`ifdef SONIC_TX_ARB_MSI_EN
  input  logic [NUM_REQ-1:0]       req_msi_ready,
  input  logic [NUM_REQ-1:0]       req_msi_busy,
  output logic [NUM_REQ-1:0]       req_msi_sel,
  input  logic [NUM_REQ-1:0]       req_msi_req,
  input  logic [NUM_REQ*5-1:0]     req_msi_num,
  input  logic [NUM_REQ*3-1:0]     req_msi_tc,
  output logic [NUM_REQ-1:0]       req_msi_ack,
  output logic                     app_msi_req,
  output logic [4:0]               app_msi_num,
  output logic [2:0]               app_msi_tc,
  input  logic                     app_msi_ack,
`endif
  output logic [TIMEOUT_CNT_W-1:0] timeout_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(GRANT_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(GRANT_TIMEOUT - 1);

  arb_state_t                tx_state, tx_state_nxt;
  logic [NUM_REQ-1:0]        tx_sel_nxt;
  logic [IDX_W-1:0]          tx_last, tx_last_nxt;
  logic [WD_W-1:0]           wd, wd_nxt;
  logic [TIMEOUT_CNT_W-1:0]  timeout_cnt_nxt;
  logic [NUM_REQ-1:0]        tx_pick_grant;
  logic [IDX_W-1:0]          tx_pick_idx;
  logic                      tx_pick_valid;
  logic                      tx_g_busy, tx_g_ready;

  sonic_rr_pick #(.NUM_REQ(NUM_REQ)) u_tx_pick (
    .req   (req_tx_ready),
    .last  (tx_last),
    .grant (tx_pick_grant),
    .idx   (tx_pick_idx),
    .valid (tx_pick_valid)
  );

  // The grant is one-hot, so masking with sel isolates the grantee without an index.
  assign tx_g_busy  = |(req_tx_busy  & req_tx_sel);
  assign tx_g_ready = |(req_tx_ready & req_tx_sel);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      tx_state    <= IDLE;
      req_tx_sel  <= '0;
      tx_last     <= IDX_W'(NUM_REQ - 1);
      wd          <= '0;
      timeout_cnt <= '0;
    end else begin
      tx_state    <= tx_state_nxt;
      req_tx_sel  <= tx_sel_nxt;
      tx_last     <= tx_last_nxt;
      wd          <= wd_nxt;
      timeout_cnt <= timeout_cnt_nxt;
    end
  end

  always_comb begin
    tx_state_nxt    = tx_state;
    tx_sel_nxt      = req_tx_sel;
    tx_last_nxt     = tx_last;
    wd_nxt          = wd;
    timeout_cnt_nxt = timeout_cnt;
    case (tx_state)
      IDLE: begin
        if (tx_pick_valid) begin
          tx_sel_nxt   = tx_pick_grant;
          tx_last_nxt  = tx_pick_idx;
          wd_nxt       = '0;
          tx_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (tx_g_busy) begin
          tx_state_nxt = HOLD;
        end else if (!tx_g_ready) begin
          tx_sel_nxt   = '0;
          tx_state_nxt = IDLE;
        end else if (wd == WD_LAST) begin
          tx_sel_nxt   = '0;
          tx_state_nxt = IDLE;
          if (timeout_cnt != '1) timeout_cnt_nxt = timeout_cnt + 1'b1;
        end else begin
          wd_nxt = wd + 1'b1;
        end
      end
      HOLD: begin
        if (!tx_g_busy) begin
          tx_sel_nxt   = '0;
          tx_state_nxt = IDLE;
        end
      end
      default: begin
        tx_sel_nxt   = '0;
        tx_state_nxt = IDLE;
      end
    endcase
  end

  // sel is all-zero in IDLE, so the AND-OR mux drives zeros to the core there.
  assign tx_req     = |(req_tx_req & req_tx_sel);
  assign tx_dv      = |(req_tx_dv  & req_tx_sel);
  assign tx_dfr     = |(req_tx_dfr & req_tx_sel);
  assign tx_err     = |(req_tx_err & req_tx_sel);
  assign req_tx_ack = req_tx_sel & {NUM_REQ{tx_ack}};
  assign req_tx_ws  = req_tx_sel & {NUM_REQ{tx_ws}};

  always_comb begin
    tx_desc = '0;
    tx_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_tx_sel[IDX_W'(i)]) begin
        tx_desc = tx_desc | req_tx_desc[i*128 +: 128];
        tx_data = tx_data | req_tx_data[i*128 +: 128];
      end
    end
  end

  always_comb begin
    req_tx_ready_others = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_tx_ready_others[IDX_W'(i)] = |(req_tx_ready & ~(NUM_REQ'(1) << i));
    end
  end

`ifdef SONIC_TX_ARB_MSI_EN
  arb_state_t         msi_state, msi_state_nxt;
  logic [NUM_REQ-1:0] msi_sel_nxt;
  logic [IDX_W-1:0]   msi_last, msi_last_nxt;
  logic [NUM_REQ-1:0] msi_pick_grant;
  logic [IDX_W-1:0]   msi_pick_idx;
  logic               msi_pick_valid;
  logic               msi_g_busy, msi_g_ready;

  sonic_rr_pick #(.NUM_REQ(NUM_REQ)) u_msi_pick (
    .req   (req_msi_ready),
    .last  (msi_last),
    .grant (msi_pick_grant),
    .idx   (msi_pick_idx),
    .valid (msi_pick_valid)
  );

  assign msi_g_busy  = |(req_msi_busy  & req_msi_sel);
  assign msi_g_ready = |(req_msi_ready & req_msi_sel);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      msi_state   <= IDLE;
      req_msi_sel <= '0;
      msi_last    <= IDX_W'(NUM_REQ - 1);
    end else begin
      msi_state   <= msi_state_nxt;
      req_msi_sel <= msi_sel_nxt;
      msi_last    <= msi_last_nxt;
    end
  end

  // Same grant/hold sequence as TX, without a watchdog.
  always_comb begin
    msi_state_nxt = msi_state;
    msi_sel_nxt   = req_msi_sel;
    msi_last_nxt  = msi_last;
    case (msi_state)
      IDLE: begin
        if (msi_pick_valid) begin
          msi_sel_nxt   = msi_pick_grant;
          msi_last_nxt  = msi_pick_idx;
          msi_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (msi_g_busy) begin
          msi_state_nxt = HOLD;
        end else if (!msi_g_ready) begin
          msi_sel_nxt   = '0;
          msi_state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (!msi_g_busy) begin
          msi_sel_nxt   = '0;
          msi_state_nxt = IDLE;
        end
      end
      default: begin
        msi_sel_nxt   = '0;
        msi_state_nxt = IDLE;
      end
    endcase
  end

  assign app_msi_req = |(req_msi_req & req_msi_sel);
  assign req_msi_ack = req_msi_sel & {NUM_REQ{app_msi_ack}};

  always_comb begin
    app_msi_num = '0;
    app_msi_tc  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_msi_sel[IDX_W'(i)]) begin
        app_msi_num = app_msi_num | req_msi_num[i*5 +: 5];
        app_msi_tc  = app_msi_tc  | req_msi_tc[i*3 +: 3];
      end
    end
  end
`endif

endmodule

// File: tb/tb_sonic_pcie_tx_arbiter.sv
// Self-checking bench for sonic_pcie_tx_arbiter: directed scenarios plus randomized traffic
// compared against a grant-ownership reference model.
module tb_sonic_pcie_tx_arbiter;

  localparam int NR      = 4;
  localparam int TIMEOUT = 1024;

  logic           clk_in = 1'b0;
  logic           reset;
  logic [NR-1:0]  req_tx_ready, req_tx_busy, req_tx_sel, req_tx_ready_others;
  logic [NR-1:0]  req_tx_req, req_tx_dv, req_tx_dfr, req_tx_err;
  logic [NR*128-1:0] req_tx_desc, req_tx_data;
  logic [NR-1:0]  req_tx_ack, req_tx_ws;
  logic           tx_req, tx_dv, tx_dfr, tx_err;
  logic [127:0]   tx_desc, tx_data;
  logic           tx_ack, tx_ws;
  logic [15:0]    timeout_cnt;
`ifdef SONIC_TX_ARB_MSI_EN
  logic [NR-1:0]   req_msi_ready, req_msi_busy, req_msi_sel, req_msi_req, req_msi_ack;
  logic [NR*5-1:0] req_msi_num;
  logic [NR*3-1:0] req_msi_tc;
  logic            app_msi_req, app_msi_ack;
  logic [4:0]      app_msi_num;
  logic [2:0]      app_msi_tc;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, whether it has started its transfer,
  // how long it has waited, and the round-robin history.
  int m_owner = -1;
  bit m_holding = 1'b0;
  int m_last = NR - 1;
  int m_age = 0;
  int m_tocnt = 0;

  sonic_pcie_tx_arbiter #(.NUM_REQ(NR), .GRANT_TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .reset(reset),
    .req_tx_ready(req_tx_ready), .req_tx_busy(req_tx_busy),
    .req_tx_sel(req_tx_sel), .req_tx_ready_others(req_tx_ready_others),
    .req_tx_req(req_tx_req), .req_tx_dv(req_tx_dv), .req_tx_dfr(req_tx_dfr),
    .req_tx_err(req_tx_err), .req_tx_desc(req_tx_desc), .req_tx_data(req_tx_data),
    .req_tx_ack(req_tx_ack), .req_tx_ws(req_tx_ws),
    .tx_req(tx_req), .tx_dv(tx_dv), .tx_dfr(tx_dfr), .tx_err(tx_err),
    .tx_desc(tx_desc), .tx_data(tx_data), .tx_ack(tx_ack), .tx_ws(tx_ws),
`ifdef SONIC_TX_ARB_MSI_EN
    .req_msi_ready(req_msi_ready), .req_msi_busy(req_msi_busy), .req_msi_sel(req_msi_sel),
    .req_msi_req(req_msi_req), .req_msi_num(req_msi_num), .req_msi_tc(req_msi_tc),
    .req_msi_ack(req_msi_ack), .app_msi_req(app_msi_req), .app_msi_num(app_msi_num),
    .app_msi_tc(app_msi_tc), .app_msi_ack(app_msi_ack),
`endif
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic compareValue(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    if (reset) begin
      m_owner = -1; m_holding = 1'b0; m_last = NR - 1; m_age = 0; m_tocnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (req_tx_ready[2'(c)]) begin
          m_owner = c; m_last = c; m_age = 0; m_holding = 1'b0;
          break;
        end
      end
    end else if (m_holding) begin
      if (!req_tx_busy[2'(m_owner)]) m_owner = -1;
    end else if (req_tx_busy[2'(m_owner)]) begin
      m_holding = 1'b1;
    end else if (!req_tx_ready[2'(m_owner)]) begin
      m_owner = -1;
    end else if (m_age == TIMEOUT - 1) begin
      m_owner = -1;
      if (m_tocnt < 65535) m_tocnt++;
    end else begin
      m_age++;
    end
  endtask

  task automatic checkOutput();
    logic [1:0]    o;
    logic [NR-1:0] exp_sel, exp_ro;
    bit            own;
    own = (m_owner >= 0);
    o = 2'(own ? m_owner : 0);
    exp_sel = own ? (4'b0001 << o) : 4'b0000;
    for (int i = 0; i < NR; i++)
      exp_ro[2'(i)] = ($countones(req_tx_ready) - int'(req_tx_ready[2'(i)])) > 0;
    compareValue("sel", req_tx_sel, exp_sel);
    compareValue("timeout_cnt", timeout_cnt, m_tocnt);
    compareValue("ctrl", {tx_req, tx_dv, tx_dfr, tx_err},
                 own ? {req_tx_req[o], req_tx_dv[o], req_tx_dfr[o], req_tx_err[o]} : 4'b0);
    compareValue("desc", tx_desc, own ? req_tx_desc[int'(o)*128 +: 128] : 128'b0);
    compareValue("data", tx_data, own ? req_tx_data[int'(o)*128 +: 128] : 128'b0);
    compareValue("ack", req_tx_ack, (own && tx_ack) ? exp_sel : 4'b0);
    compareValue("ws", req_tx_ws, (own && tx_ws) ? exp_sel : 4'b0);
    compareValue("ready_others", req_tx_ready_others, exp_ro);
  endtask

  task automatic applyStimulus();
    modelEdge();
    @(posedge clk_in);
    #1;
    checkOutput();
  endtask

  initial begin
    reset = 1'b1;
    req_tx_ready = '0; req_tx_busy = '0;
    req_tx_req = '0; req_tx_dv = '0; req_tx_dfr = '0; req_tx_err = '0;
    req_tx_desc = '0; req_tx_data = '0; tx_ack = 1'b0; tx_ws = 1'b0;
`ifdef SONIC_TX_ARB_MSI_EN
    req_msi_ready = '0; req_msi_busy = '0; req_msi_req = '0;
    req_msi_num = '0; req_msi_tc = '0; app_msi_ack = 1'b0;
`endif
    #1;
    applyStimulus();
    applyStimulus();
    compareValue("rst_sel", req_tx_sel, 4'b0000);
    compareValue("rst_tcnt", timeout_cnt, 16'd0);
    reset = 1'b0;
    applyStimulus();

`ifdef SONIC_TX_ARB_MSI_EN
    req_msi_ready = 4'b1010;
    req_msi_num[3*5 +: 5] = 5'd7;
    applyStimulus();
    compareValue("msi_first", req_msi_sel, 4'b0010);
    req_msi_busy = 4'b0010;
    applyStimulus();
    req_msi_busy = 4'b0000;
    applyStimulus();
    compareValue("msi_gap", req_msi_sel, 4'b0000);
    req_msi_req = 4'b1000;
    applyStimulus();
    compareValue("msi_second", req_msi_sel, 4'b1000);
    compareValue("msi_num", app_msi_num, 5'd7);
    compareValue("msi_req", app_msi_req, 1'b1);
    req_msi_ready = 4'b0000; req_msi_req = 4'b0000;
    applyStimulus();
    compareValue("msi_drop", req_msi_sel, 4'b0000);
`endif

    // Two ready requesters, 0 wins first after reset, 2 follows after one idle cycle.
    req_tx_ready = 4'b0101;
    applyStimulus();
    compareValue("t1_first", req_tx_sel, 4'b0001);
    req_tx_busy = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      compareValue("t1_hold", req_tx_sel, 4'b0001);
    end
    req_tx_busy = 4'b0000;
    applyStimulus();
    compareValue("t1_gap", req_tx_sel, 4'b0000);
    applyStimulus();
    compareValue("t1_second", req_tx_sel, 4'b0100);
    // Requester 2 withdraws one cycle after its grant.
    req_tx_ready = 4'b0000;
    applyStimulus();
    compareValue("wd_sel", req_tx_sel, 4'b0000);
    compareValue("wd_tcnt", timeout_cnt, 16'd0);

    // Requester 3 in HOLD: data and ack steered, foreign busy ignored.
    req_tx_ready = 4'b1000;
    applyStimulus();
    compareValue("h_grant", req_tx_sel, 4'b1000);
    req_tx_busy = 4'b1000; tx_ack = 1'b1;
    req_tx_data[3*128 +: 128] = {16{8'hA5}};
    applyStimulus();
    compareValue("h_data", tx_data, {16{8'hA5}});
    compareValue("h_ack", req_tx_ack, 4'b1000);
    req_tx_busy = 4'b1010;
    applyStimulus();
    compareValue("h_foreign_busy", req_tx_sel, 4'b1000);
    req_tx_busy = 4'b0010;
    applyStimulus();
    compareValue("h_release", req_tx_sel, 4'b0000);
    req_tx_busy = 4'b0000; tx_ack = 1'b0;

    // All ready: order 0,1,2,3,0 with one idle cycle between grants.
    req_tx_ready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [NR-1:0] expect_sel;
      expect_sel = 4'b0001 << (k % NR);
      applyStimulus();
      compareValue("rr_grant", req_tx_sel, expect_sel);
      req_tx_busy = expect_sel;
      applyStimulus();
      applyStimulus();
      req_tx_busy = 4'b0000;
      applyStimulus();
      compareValue("rr_gap", req_tx_sel, 4'b0000);
    end

    // Requester 1 never goes busy: watchdog expires after TIMEOUT cycles in GRANT.
    req_tx_ready = 4'b0010;
    applyStimulus();
    compareValue("to_grant", req_tx_sel, 4'b0010);
    req_tx_ready = 4'b0110;
    for (int k = 0; k < TIMEOUT - 1; k++) applyStimulus();
    compareValue("to_last_cycle", req_tx_sel, 4'b0010);
    applyStimulus();
    compareValue("to_drop", req_tx_sel, 4'b0000);
    compareValue("to_count", timeout_cnt, 16'd1);
    applyStimulus();
    compareValue("to_next", req_tx_sel, 4'b0100);
    req_tx_ready = 4'b0000;
    applyStimulus();

    // Reset while holding drops the grant on the next edge.
    req_tx_ready = 4'b0001;
    applyStimulus();
    req_tx_busy = 4'b0001;
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    compareValue("rst_hold", req_tx_sel, 4'b0000);
    reset = 1'b0; req_tx_busy = 4'b0000; req_tx_ready = 4'b0000;
    applyStimulus();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int w = 0; w < NR * 4; w++) begin
        req_tx_desc[w*32 +: 32] = $urandom;
        req_tx_data[w*32 +: 32] = $urandom;
      end
      req_tx_req = 4'($urandom); req_tx_dv = 4'($urandom);
      req_tx_dfr = 4'($urandom); req_tx_err = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_tx_ready = 4'($urandom);
      req_tx_busy = 4'($urandom) & 4'($urandom);
      tx_ack = 1'($urandom); tx_ws = 1'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sonic_pcie_tx_arbiter.md
# sonic_pcie_tx_arbiter

Shares the single PCIe Avalon-ST TX port, and optionally the MSI request port, between NUM_REQ requesters: per-port IRQ controllers and DMA engines. Each requester raises `tx_ready` when it has a TLP pending. The arbiter grants one requester at a time (`tx_sel`) using round-robin order, holds the grant while the requester is busy, and muxes that requester's TX signals onto the core. It sits between the per-port `sonic_irq_ctl`/DMA instances and the PCIe hard IP.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- GRANT_TIMEOUT, 1024: cycles allowed in GRANT before `tx_busy` must rise. Must be ≥ 2.

Ports:
- clk_in  in  1  core clock. All logic is in this single domain.
- reset  in  1  synchronous, active-high reset.
- req_tx_ready  in  NUM_REQ  requester i has a TLP pending.
- req_tx_busy  in  NUM_REQ  requester i is mid-transaction.
- req_tx_sel  out  NUM_REQ  one-hot grant, registered.
- req_tx_ready_others  out  NUM_REQ  bit i = OR of req_tx_ready[j] for all j≠i. Combinational.
- req_tx_req, req_tx_dv, req_tx_dfr, req_tx_err  in  NUM_REQ each  per-requester TX controls.
- req_tx_desc, req_tx_data  in  NUM_REQ*128  flattened; requester i occupies bits [128i+127:128i].
- req_tx_ack, req_tx_ws  out  NUM_REQ  core ack/ws steered to the granted requester only.
- tx_req, tx_dv, tx_dfr, tx_err  out  1  to core.
- tx_desc, tx_data  out  128  to core.
- tx_ack, tx_ws  in  1  from core.
- timeout_cnt  out  16  saturating count of grant timeouts.
- The following exist only with SONIC_TX_ARB_MSI_EN defined:
  - req_msi_ready, req_msi_busy  in  NUM_REQ.
  - req_msi_sel  out  NUM_REQ.
  - req_msi_req  in  NUM_REQ.
  - req_msi_num  in  NUM_REQ*5.
  - req_msi_tc  in  NUM_REQ*3.
  - req_msi_ack  out  NUM_REQ.
  - app_msi_req  out  1.
  - app_msi_num  out  5.
  - app_msi_tc  out  3.
  - app_msi_ack  in  1.

## Operation
TX FSM states: IDLE, GRANT, HOLD.
- IDLE: if any req_tx_ready bit is set, pick the first set bit searching upward from (last+1) mod NUM_REQ. Then:
  - set req_tx_sel to that one-hot pattern;
  - set last to the picked index;
  - clear the watchdog counter;
  - go to GRANT.
- GRANT:
  - If req_tx_busy[g] is set, go to HOLD.
  - Otherwise, if req_tx_ready[g] is clear (requester withdrew), clear sel and go to IDLE.
  - Otherwise, if the watchdog equals GRANT_TIMEOUT-1, clear sel, increment timeout_cnt (saturating at 0xFFFF), and go to IDLE.
- HOLD: when req_tx_busy[g] falls, clear sel and go to IDLE.
- Busy takes precedence over withdraw and timeout when they occur in the same cycle.
- Mux in GRANT and HOLD:
  - Core outputs equal granted requester g's signals.
  - req_tx_ack[g] = tx_ack and req_tx_ws[g] = tx_ws.
  - All other req_tx_ack/req_tx_ws bits are 0.
- Mux in IDLE: all core outputs and all req_tx_ack/req_tx_ws bits are 0; tx_ws is ignored.
- Busy asserted by a non-granted requester is ignored.

## Timing
- Reset values:
  - state IDLE;
  - req_tx_sel 0;
  - last = NUM_REQ-1, so requester 0 wins first;
  - watchdog 0;
  - timeout_cnt 0;
  - all core-side TX outputs 0;
  - MSI outputs 0 and MSI FSM idle.
- Latency:
  - req_tx_ready rising in IDLE at cycle n → req_tx_sel high at n+1.
  - req_tx_busy[g] falling at cycle n → sel low at n+1.
  - Next grant earliest at n+2, so there is one idle cycle between grants.
- Mux paths are purely combinational from req_tx_sel (which is registered): zero added latency, no bubbles within a TLP.
- Reset asserted mid-HOLD: the grant drops on the next edge. The requester is responsible for its own recovery.

## Configuration
- SONIC_TX_ARB_MSI_EN defined:
  - A second, independent instance of the same IDLE/GRANT/HOLD FSM arbitrates MSI on req_msi_ready/req_msi_busy with its own round-robin pointer. It has no watchdog.
  - app_msi_req, app_msi_num, app_msi_tc are muxed from the MSI grantee.
  - app_msi_ack is steered to req_msi_ack[grantee].
- Not defined: MSI ports are absent and no MSI logic is generated; each requester keeps its own MSI connection.

## Structure
- Package sonic_arb_pkg contains:
  - the enum arb_state_t (IDLE, GRANT, HOLD);
  - localparam TIMEOUT_CNT_W = 16.
- Sub-module sonic_rr_pick: combinational round-robin picker.
  - Inputs: request vector, last index.
  - Outputs: one-hot grant, index, valid.
  - Instantiated once per FSM.

## Test plan
- Reset, then req_tx_ready=4'b0101 held → sel 0001 at cycle 1. Busy[0] high 3 cycles then low → sel 0000 for one cycle, then 0100.
- All four ready continuously, each busy 2 cycles → grant order 0,1,2,3,0, with exactly one idle cycle between grants.
- Grant to requester 1 with busy never asserted and ready held → sel drops after 1024 cycles, timeout_cnt=1, requester 2 is granted next.
- req_tx_ready[2] withdrawn one cycle after grant → IDLE next cycle, timeout_cnt unchanged.
- In HOLD with g=3, tx_ack=1 and req_tx_data[3]=0xA5…A5 → tx_data=0xA5…A5, req_tx_ack=4'b1000. Busy[1] pulsed during HOLD → ignored.
- With SONIC_TX_ARB_MSI_EN: req_msi_ready=4'b1010, req_msi_num[3]=5'd7 → msi_sel=0010 first. After requester 1's busy falls → msi_sel=1000, and app_msi_num=7 while req_msi_req[3] is high.
